// File: rtl/pdm_playback.sv
// Sample-RAM playback onto a first-order sigma-delta PDM amplifier output.
// Define PDM_PLAY_LOOP_EN to loop the buffer until stop instead of single-shot.
module pdm_playback #(
  parameter int ADDR_W  = 14,
  parameter int CLK_DIV = 50,
  parameter int OSR     = 64
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              play,
  input  logic              stop,
  input  logic [ADDR_W-1:0] num_words,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              ampPWM,
  output logic              ampSD
);

`ifdef PDM_PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_PLAY  = 2'd3;

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int OW = $clog2(OSR) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [OW-1:0] OSR_LAST = OW'(OSR - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] nwords;
  logic [31:0]       cur_word;
  logic [31:0]       next_word;
  logic [15:0]       acc;
  logic [DW-1:0]     div;
  logic [OW-1:0]     bcnt;
  logic              half;
  logic              pf_lat;

  logic              tick;
  logic              last_bit;
  logic              last_word;
  logic              more;
  logic [ADDR_W-1:0] nxt_addr;
  logic [15:0]       smp;
  logic [15:0]       u;
  logic [16:0]       sum;

  assign tick      = (state == S_PLAY) && (div == DIV_LAST);
  assign last_bit  = bcnt == OSR_LAST;
  assign last_word = addr == nwords - 1'b1;
  assign more      = LOOP || !last_word;
  assign nxt_addr  = (LOOP && last_word) ? '0 : addr + 1'b1;
  assign smp       = half ? cur_word[31:16] : cur_word[15:0];
  // Offset binary so -32768 maps to zero ones density.
  assign u         = {~smp[15], smp[14:0]};
  assign sum       = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= S_IDLE;
      addr        <= '0;
      nwords      <= '0;
      cur_word    <= '0;
      next_word   <= '0;
      acc         <= '0;
      div         <= '0;
      bcnt        <= '0;
      half        <= 1'b0;
      pf_lat      <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ampPWM      <= 1'b0;
      ampSD       <= 1'b0;
    end else begin
      done      <= 1'b0;
      ram_rd_en <= 1'b0;
      if (ram_rd_en && state == S_PLAY) pf_lat <= 1'b1;
      if (pf_lat) begin
        next_word <= ram_rd_data;
        pf_lat    <= 1'b0;
      end
      if (state != S_IDLE && stop) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        ampSD  <= 1'b0;
        ampPWM <= 1'b0;
        pf_lat <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (play && !stop) begin
              if (num_words != '0) begin
                state       <= S_FETCH;
                nwords      <= num_words;
                addr        <= '0;
                ram_rd_en   <= 1'b1;
                ram_rd_addr <= '0;
                busy        <= 1'b1;
                acc         <= '0;
                bcnt        <= '0;
                half        <= 1'b0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            state <= S_LOAD;
            ampSD <= 1'b1;
            div   <= '0;
          end
          S_LOAD: begin
            cur_word <= ram_rd_data;
            state    <= S_PLAY;
            div      <= div + 1'b1;
          end
          default: begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
              ampPWM <= sum[16];
              acc    <= sum[15:0];
              bcnt   <= last_bit ? '0 : bcnt + 1'b1;
              if (last_bit && !half) begin
                half <= 1'b1;
                if (more) begin
                  ram_rd_en   <= 1'b1;
                  ram_rd_addr <= nxt_addr;
                end
              end
              if (last_bit && half) begin
                if (more) begin
                  cur_word <= next_word;
                  addr     <= nxt_addr;
                  half     <= 1'b0;
                end else begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  ampSD  <= 1'b0;
                  ampPWM <= 1'b0;
                  done   <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdm_playback.sv
// Directed bench for pdm_playback with CLK_DIV=4, OSR=8.
// Loop-mode steps build only when PDM_PLAY_LOOP_EN is defined.
module tb_pdm_playback;

  logic        clk;
  logic        reset_L;
  logic        play;
  logic        stop;
  logic [13:0] num_words;
  logic        ram_rd_en;
  logic [13:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        busy;
  logic        done;
  logic        ampPWM;
  logic        ampSD;

  int checks;
  int failures;

  logic [31:0] mem [0:3];
  logic [13:0] rd_q [$];
  logic [31:0] got;
  int          k;

  pdm_playback #(.ADDR_W(14), .CLK_DIV(4), .OSR(8)) dut (
    .clk(clk),
    .reset_L(reset_L),
    .play(play),
    .stop(stop),
    .num_words(num_words),
    .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .busy(busy),
    .done(done),
    .ampPWM(ampPWM),
    .ampSD(ampSD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rd_data <= mem[ram_rd_addr[1:0]];
      rd_q.push_back(ram_rd_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_L = 1'b0;
    play = 1'b0;
    stop = 1'b0;
    num_words = '0;
    ram_rd_data = '0;
    repeat (2) clk1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sd", 32'(ampSD), 0);
    chk("rst_pwm", 32'(ampPWM), 0);
    chk("rst_rden", 32'(ram_rd_en), 0);
    chk("rst_done", 32'(done), 0);
    reset_L = 1'b1;
    clk1;

    // num_words == 0: done only
    rd_q.delete();
    play = 1'b1;
    num_words = 14'd0;
    clk1;
    play = 1'b0;
    chk("nw0_done", 32'(done), 1);
    chk("nw0_busy", 32'(busy), 0);
    chk("nw0_sd", 32'(ampSD), 0);
    chk("nw0_rden", 32'(ram_rd_en), 0);
    clk1;
    chk("nw0_done_pulse", 32'(done), 0);
    chk("nw0_reads", 32'(rd_q.size()), 0);

    // stop beats play in IDLE
    play = 1'b1;
    stop = 1'b1;
    num_words = 14'd2;
    clk1;
    play = 1'b0;
    stop = 1'b0;
    chk("sp_busy", 32'(busy), 0);
    chk("sp_rden", 32'(ram_rd_en), 0);
    chk("sp_done", 32'(done), 0);
    clk1;

`ifndef PDM_PLAY_LOOP_EN
    // two words: full-scale low/high then midscale
    mem[0] = 32'h7FFF_8000;
    mem[1] = 32'h0000_0000;
    rd_q.delete();
    got = '0;
    play = 1'b1;
    num_words = 14'd2;
    clk1;
    play = 1'b0;
    chk("t2_rden0", 32'(ram_rd_en), 1);
    chk("t2_addr0", 32'(ram_rd_addr), 0);
    chk("t2_busy", 32'(busy), 1);
    clk1;
    chk("t2_sd", 32'(ampSD), 1);
    chk("t2_rden_pulse", 32'(ram_rd_en), 0);
    for (int e = 2; e <= 129; e++) begin
      clk1;
      if (e >= 5 && e <= 125 && (e - 1) % 4 == 0) begin
        k = (e - 1) / 4;
        got[k-1] = ampPWM;
      end
      if (e == 50) begin
        play = 1'b1;
        num_words = 14'd5;
      end
      if (e == 51) play = 1'b0;
      if (e == 100) chk("t2_sd_mid", 32'(ampSD), 1);
      if (e == 128) begin
        chk("t2_done_early", 32'(done), 0);
        chk("t2_busy_late", 32'(busy), 1);
      end
      if (e == 129) begin
        chk("t2_done", 32'(done), 1);
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_sd_end", 32'(ampSD), 0);
        chk("t2_pwm_end", 32'(ampPWM), 0);
      end
    end
    chk("t2_bits", got, 32'h5555_FE00);
    chk("t2_nreads", 32'(rd_q.size()), 2);
    if (rd_q.size() == 2) begin
      chk("t2_rd0", 32'(rd_q[0]), 0);
      chk("t2_rd1", 32'(rd_q[1]), 1);
    end
    clk1;
    chk("t2_done_pulse", 32'(done), 0);

    // midscale single word alternates
    mem[0] = 32'h0000_0000;
    got = '0;
    play = 1'b1;
    num_words = 14'd1;
    clk1;
    play = 1'b0;
    for (int e = 1; e <= 65; e++) begin
      clk1;
      if (e >= 5 && e <= 61 && (e - 1) % 4 == 0) begin
        k = (e - 1) / 4;
        got[k-1] = ampPWM;
      end
      if (e == 65) chk("t3_done", 32'(done), 1);
    end
    chk("t3_bits", got, 32'h0000_2AAA);
    chk("t3_ones", 32'($countones(got)), 7);
    clk1;
`endif

    // stop during PLAY
    mem[0] = 32'h7FFF_7FFF;
    mem[1] = 32'h7FFF_7FFF;
    play = 1'b1;
    num_words = 14'd2;
    clk1;
    play = 1'b0;
    for (int e = 1; e <= 11; e++) clk1;
    chk("t5_pwm_pre", 32'(ampPWM), 1);
    stop = 1'b1;
    clk1;
    stop = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_sd", 32'(ampSD), 0);
    chk("t5_pwm", 32'(ampPWM), 0);
    chk("t5_done", 32'(done), 0);
    clk1;
    chk("t5_done_after", 32'(done), 0);
    play = 1'b1;
    clk1;
    play = 1'b0;
    chk("t5_restart_en", 32'(ram_rd_en), 1);
    chk("t5_restart_addr", 32'(ram_rd_addr), 0);
    stop = 1'b1;
    clk1;
    stop = 1'b0;
    chk("t5_stop2", 32'(busy), 0);

    // async reset mid-PLAY
    mem[0] = 32'h7FFF_7FFF;
    play = 1'b1;
    num_words = 14'd1;
    clk1;
    play = 1'b0;
    for (int e = 1; e <= 20; e++) clk1;
    chk("t1_sd_pre", 32'(ampSD), 1);
    chk("t1_pwm_pre", 32'(ampPWM), 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 0);
    chk("t1_sd", 32'(ampSD), 0);
    chk("t1_pwm", 32'(ampPWM), 0);
    chk("t1_rden", 32'(ram_rd_en), 0);
    repeat (3) clk1;
    reset_L = 1'b1;
    repeat (3) clk1;
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_sd", 32'(ampSD), 0);

`ifdef PDM_PLAY_LOOP_EN
    // looping playback wraps addresses and never finishes
    mem[0] = 32'h1111_2222;
    mem[1] = 32'h3333_4444;
    mem[2] = 32'h5555_6666;
    rd_q.delete();
    k = 0;
    play = 1'b1;
    num_words = 14'd3;
    clk1;
    play = 1'b0;
    for (int e = 1; e <= 330; e++) begin
      clk1;
      if (done) k++;
    end
    chk("lp_no_done", 32'(k), 0);
    chk("lp_busy", 32'(busy), 1);
    chk("lp_nreads_ok", 32'(rd_q.size() >= 5), 1);
    if (rd_q.size() >= 5) begin
      chk("lp_rd0", 32'(rd_q[0]), 0);
      chk("lp_rd1", 32'(rd_q[1]), 1);
      chk("lp_rd2", 32'(rd_q[2]), 2);
      chk("lp_rd3", 32'(rd_q[3]), 0);
      chk("lp_rd4", 32'(rd_q[4]), 1);
    end
    stop = 1'b1;
    clk1;
    stop = 1'b0;
    chk("lp_stop_busy", 32'(busy), 0);
    chk("lp_stop_done", 32'(done), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
